sc_score_engine: RTL
====================

// Module: sc_score_engine
// PURPOSE
//  Parametrised scoring engine for the SC block. Accepts per-fret hit/miss events from note matching,
//  grades each hit by timing error against song_time, and maintains combo, multiplier and saturating score.
//  Emits one graded event per handshake to the AV block.
//  Generalises the single-output score path to NUM_FRETS channels with grading windows and backpressure.
// PARAMETERS
//  NUM_FRETS    5    number of fret channels
//  TIME_W       16   width of song_time / note times
//  SCORE_W      24   score accumulator width
//  PERFECT_WIN  8    max |dt| (time units) graded PERFECT
//  GOOD_WIN     24   max |dt| graded GOOD (must be >= PERFECT_WIN)
//  COMBO_STEP   10   combo hits per multiplier increment
//  MAX_MULT     4    multiplier ceiling (1..7)
// PORTS
//  clk        in   1                   100 MHz system clock
//  reset      in   1                   synchronous, active-high
//  pause      in   1                   game paused; arbitration halts
//  song_time  in   TIME_W              current song time
//  hit_valid  in   NUM_FRETS           1-cycle pulse: note matched on fret i
//  hit_time   in   NUM_FRETS*TIME_W    matched note time, fret i at [i*TIME_W +: TIME_W]
//  miss_valid in   NUM_FRETS           1-cycle pulse: note on fret i expired unplayed
//  score      out  SCORE_W             running score
//  combo      out  16                  consecutive non-miss count
//  multiplier out  3                   current multiplier, 1..MAX_MULT
//  evt_valid  out  1                   graded event available
//  evt_ready  in   1                   AV block accepts event
//  evt_fret   out  $clog2(NUM_FRETS)   fret of event
//  evt_grade  out  2                   11 PERFECT, 10 GOOD, 01 LATE, 00 MISS
//  evt_dt     out  TIME_W              |dt| of the graded hit (0 for MISS)
//  overflow   out  1                   sticky: an event was dropped
// BEHAVIOUR
//  Reset: score=0, combo=0, multiplier=1, evt_valid=0, evt_fret/grade/dt=0, overflow=0, all slots empty, rr ptr=0.
//  Capture: each fret owns a 1-entry pending slot {kind,time}. Pulse at cycle N -> slot full at N+1.
//   hit_valid and miss_valid together on one fret: hit wins, miss discarded, no overflow.
//   Pulse on a full slot not being drained that cycle: new event dropped, overflow<=1 (until reset).
//   Slots capture during pause.
//  Arbiter: when !pause and stage-1 register free or advancing, grant one full slot, round-robin
//   starting at (last granted+1) mod NUM_FRETS; granted slot clears same edge (may refill same edge).
//  Stage 1 (grade): raw = song_time - hit_time mod 2^TIME_W; dt = min(raw, 2^TIME_W - raw).
//   dt<=PERFECT_WIN -> PERFECT(100 pts); dt<=GOOD_WIN -> GOOD(50); else LATE(10). miss slot -> MISS(0).
//   song_time is sampled at grant, not at capture.
//  Stage 2 (score): non-MISS: combo<=combo+1 (saturate 0xFFFF); MISS: combo<=0.
//   multiplier = min(1 + new_combo/COMBO_STEP, MAX_MULT); score += pts*multiplier, saturate at 2^SCORE_W-1.
//   score/combo/multiplier and evt_* update on the same edge; evt_valid<=1.
//  Latency: pulse at N, uncontended, ready high -> evt_valid and score updated at N+3.
//  Handshake: evt_* held stable while evt_valid && !evt_ready; stage 2 and stage 1 stall,
//   arbiter grants nothing; slots keep capturing (overflow rules apply). Transfer on valid&&ready.
//  Pause: no new grants; in-flight stage-1/stage-2 events complete normally.
//  Reset mid-operation: all state returns to reset values next edge; in-flight events discarded.
// STRUCTURE
//  sc_pkg: grade encodings, GRADE_* point constants, localparam FRET_W = $clog2(NUM_FRETS).
//  Sub-module sc_fret_arbiter: NUM_FRETS-wide round-robin grant with enable, one-hot grant + index.
//  Top holds slots, 2-stage pipeline, score/combo registers; multiplier by compare, not divider.
// TESTING
//  hit fret2 time=1000 at song_time=1005, ready=1 -> N+3: grade=11, dt=5, score=100, combo=1, mult=1.
//  10 PERFECT hits on frets 0..4 round-robin -> 10th event mult=2, score=900+200=1100; then miss -> combo=0, mult=1.
//  hits on all 5 frets same cycle -> events emerge fret 0,1,2,3,4 on 5 consecutive cycles; rr next starts at 0.
//  song_time=0x0003, hit_time=0xFFFE -> dt=5 PERFECT (wrap); hit_time=0x0020 at song_time=0 -> dt=32 LATE.
//  evt_ready=0 for 6 cycles, 2 pulses on fret1 -> second dropped, overflow=1, evt_* stable; release -> drain in order.
//  score preset near max (SCORE_W=8 build), PERFECT -> score=255 saturates; reset mid-stall -> all outputs reset next edge.

Source files
------------

// File: rtl/sc_score_engine_pkg.sv
// Shared types and constants for the SC scoring engine: grade encodings,
// point values per grade and a helper for sizing fret index fields.
package sc_score_engine_pkg;

   typedef enum logic [1:0] {
      GRADE_MISS    = 2'b00,
      GRADE_LATE    = 2'b01,
      GRADE_GOOD    = 2'b10,
      GRADE_PERFECT = 2'b11
   } grade_t;

   typedef enum logic {
      SLOT_MISS = 1'b0,
      SLOT_HIT  = 1'b1
   } slot_kind_t;

   localparam int PTS_W       = 7;
   localparam int PTS_PERFECT = 100;
   localparam int PTS_GOOD    = 50;
   localparam int PTS_LATE    = 10;
   localparam int PTS_MISS    = 0;

   localparam int COMBO_W     = 16;
   localparam int MULT_W      = 3;

   // A single-fret build still needs a 1-bit index field.
   function automatic int fret_width(input int num_frets);
      return (num_frets > 1) ? $clog2(num_frets) : 1;
   endfunction

   function automatic logic [PTS_W-1:0] grade_points(input grade_t grade);
      case (grade)
         GRADE_PERFECT: return PTS_W'(PTS_PERFECT);
         GRADE_GOOD:    return PTS_W'(PTS_GOOD);
         GRADE_LATE:    return PTS_W'(PTS_LATE);
         default:       return PTS_W'(PTS_MISS);
      endcase
   endfunction

endpackage

// File: rtl/sc_score_engine_if.sv
// Graded-event handshake from the scoring engine to the AV block.
interface sc_score_engine_if #(
   parameter int NUM_FRETS = 5,
   parameter int TIME_W    = 16
);
   import sc_score_engine_pkg::*;

   localparam int FRET_W = fret_width(NUM_FRETS);

   logic              evt_valid;
   logic              evt_ready;
   logic [FRET_W-1:0] evt_fret;
   grade_t            evt_grade;
   logic [TIME_W-1:0] evt_dt;

   modport master (
      output evt_valid,
      output evt_fret,
      output evt_grade,
      output evt_dt,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_fret,
      input  evt_grade,
      input  evt_dt,
      output evt_ready
   );

endinterface

// File: rtl/sc_fret_arbiter.sv
// Round-robin arbiter over the fret pending slots. The search starts one
// past the most recently granted fret so no fret can starve another.
module sc_fret_arbiter #(
   parameter int NUM_FRETS = 5,
   parameter int IDX_W     = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_FRETS-1:0] req,
   output logic [NUM_FRETS-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 grant_valid
);

   logic [IDX_W-1:0] next_ptr;

   // Pick the first requesting fret at or after the pointer, wrapping around.
   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      if (enable) begin
         for (int off = 0; off < NUM_FRETS; off++) begin
            idx = int'(next_ptr) + off;
            if (idx >= NUM_FRETS) begin
               idx = idx - NUM_FRETS;
            end
            if (!grant_valid && req[idx]) begin
               grant_valid = 1'b1;
               grant[idx]  = 1'b1;
               grant_idx   = IDX_W'(idx);
            end
         end
      end
   end

   // Advance the search start to the fret after the one just granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         next_ptr <= '0;
      end else if (grant_valid) begin
         if (grant_idx == IDX_W'(NUM_FRETS - 1)) begin
            next_ptr <= '0;
         end else begin
            next_ptr <= grant_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sc_score_engine.sv
// SC scoring engine: captures per-fret hit/miss pulses into one-deep slots,
// arbitrates them into a grade stage and a score stage, and hands each graded
// event to the AV block while keeping combo, multiplier and saturating score.
module sc_score_engine
   import sc_score_engine_pkg::*;
#(
   parameter int NUM_FRETS   = 5,
   parameter int TIME_W      = 16,
   parameter int SCORE_W     = 24,
   parameter int PERFECT_WIN = 8,
   parameter int GOOD_WIN    = 24,
   parameter int COMBO_STEP  = 10,
   parameter int MAX_MULT    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        pause,
   input  logic [TIME_W-1:0]           song_time,
   input  logic [NUM_FRETS-1:0]        hit_valid,
   input  logic [NUM_FRETS*TIME_W-1:0] hit_time,
   input  logic [NUM_FRETS-1:0]        miss_valid,
   output logic [SCORE_W-1:0]          score,
   output logic [COMBO_W-1:0]          combo,
   output logic [MULT_W-1:0]           multiplier,
   output logic                        overflow,
   sc_score_engine_if.master           evt
);

   localparam int FRET_W = fret_width(NUM_FRETS);
   // Points (<=100) times multiplier (<=7) always fits in 10 bits.
   localparam int GAIN_W = 10;
   localparam int SUM_W  = ((SCORE_W > GAIN_W) ? SCORE_W : GAIN_W) + 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic [NUM_FRETS-1:0] slot_full;
   slot_kind_t           slot_kind [NUM_FRETS];
   logic [TIME_W-1:0]    slot_time [NUM_FRETS];

   logic                 stall;
   logic                 arb_en;
   logic [NUM_FRETS-1:0] grant_onehot;
   logic [FRET_W-1:0]    grant_idx;
   logic                 grant_valid;

   slot_kind_t           sel_kind;
   logic [TIME_W-1:0]    sel_time;
   logic [TIME_W-1:0]    raw_dt;
   logic [TIME_W-1:0]    neg_dt;
   logic [TIME_W-1:0]    abs_dt;
   grade_t               sel_grade;
   logic [TIME_W-1:0]    sel_dt;

   logic                 s1_valid;
   logic [FRET_W-1:0]    s1_fret;
   grade_t               s1_grade;
   logic [TIME_W-1:0]    s1_dt;

   logic [COMBO_W-1:0]   new_combo;
   logic [MULT_W-1:0]    new_mult;
   logic [GAIN_W-1:0]    gain;
   logic [SUM_W-1:0]     sum;
   logic [SCORE_W-1:0]   new_score;

   // A held event blocks the whole pipeline; pause only blocks new grants.
   always_comb begin
      stall  = evt.evt_valid && !evt.evt_ready;
      arb_en = !pause && !stall;
   end

   sc_fret_arbiter #(
      .NUM_FRETS (NUM_FRETS),
      .IDX_W     (FRET_W)
   ) u_arbiter (
      .clk         (clk),
      .reset       (reset),
      .enable      (arb_en),
      .req         (slot_full),
      .grant       (grant_onehot),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Capture pulses into slots; a hit beats a simultaneous miss, and a pulse
   // landing on an occupied slot that is not draining this edge is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         for (int i = 0; i < NUM_FRETS; i++) begin
            slot_full[i] <= 1'b0;
            slot_kind[i] <= SLOT_MISS;
            slot_time[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FRETS; i++) begin
            if (hit_valid[i] || miss_valid[i]) begin
               if (slot_full[i] && !grant_onehot[i]) begin
                  overflow <= 1'b1;
               end else begin
                  slot_full[i] <= 1'b1;
                  slot_kind[i] <= hit_valid[i] ? SLOT_HIT : SLOT_MISS;
                  slot_time[i] <= hit_valid[i] ? hit_time[i*TIME_W +: TIME_W] : '0;
               end
            end else if (grant_onehot[i]) begin
               slot_full[i] <= 1'b0;
            end
         end
      end
   end

   // Grade the granted slot against the current song time using the shorter
   // way round the wrapping time base.
   always_comb begin
      sel_kind = SLOT_MISS;
      sel_time = '0;
      for (int i = 0; i < NUM_FRETS; i++) begin
         if (grant_onehot[i]) begin
            sel_kind = slot_kind[i];
            sel_time = slot_time[i];
         end
      end
      raw_dt = song_time - sel_time;
      neg_dt = '0 - raw_dt;
      abs_dt = (raw_dt < neg_dt) ? raw_dt : neg_dt;
      if (sel_kind == SLOT_MISS) begin
         sel_grade = GRADE_MISS;
         sel_dt    = '0;
      end else if (abs_dt <= TIME_W'(PERFECT_WIN)) begin
         sel_grade = GRADE_PERFECT;
         sel_dt    = abs_dt;
      end else if (abs_dt <= TIME_W'(GOOD_WIN)) begin
         sel_grade = GRADE_GOOD;
         sel_dt    = abs_dt;
      end else begin
         sel_grade = GRADE_LATE;
         sel_dt    = abs_dt;
      end
   end

   // Stage 1 register: holds the graded event until the score stage takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_fret  <= '0;
         s1_grade <= GRADE_MISS;
         s1_dt    <= '0;
      end else if (!stall) begin
         s1_valid <= grant_valid;
         s1_fret  <= grant_idx;
         s1_grade <= sel_grade;
         s1_dt    <= sel_dt;
      end
   end

   // Next combo, multiplier (threshold compares instead of a divider) and
   // saturating score for the event leaving stage 1.
   always_comb begin
      if (s1_grade == GRADE_MISS) begin
         new_combo = '0;
      end else if (combo == '1) begin
         new_combo = combo;
      end else begin
         new_combo = combo + 1'b1;
      end
      new_mult = MULT_W'(1);
      for (int k = 1; k < MAX_MULT; k++) begin
         if (int'(new_combo) >= k * COMBO_STEP) begin
            new_mult = MULT_W'(k + 1);
         end
      end
      gain = GAIN_W'(grade_points(s1_grade)) * GAIN_W'(new_mult);
      sum  = SUM_W'(score) + SUM_W'(gain);
      if (sum > SUM_W'(SCORE_MAX)) begin
         new_score = SCORE_MAX;
      end else begin
         new_score = sum[SCORE_W-1:0];
      end
   end

   // Stage 2: publish the event and commit the score state together.
   always_ff @(posedge clk) begin
      if (reset) begin
         evt.evt_valid <= 1'b0;
         evt.evt_fret  <= '0;
         evt.evt_grade <= GRADE_MISS;
         evt.evt_dt    <= '0;
         score         <= '0;
         combo         <= '0;
         multiplier    <= MULT_W'(1);
      end else if (!stall) begin
         if (s1_valid) begin
            evt.evt_valid <= 1'b1;
            evt.evt_fret  <= s1_fret;
            evt.evt_grade <= s1_grade;
            evt.evt_dt    <= s1_dt;
            score         <= new_score;
            combo         <= new_combo;
            multiplier    <= new_mult;
         end else begin
            evt.evt_valid <= 1'b0;
         end
      end
   end

endmodule
